// File: rtl/ex_stage.sv
// ex_stage: execute stage with built-in EX/MEM register, accumulator forwarding
// and an iterative shift-add multiplier that stalls the upstream pipeline.
`default_nettype none

module ex_stage #(
  parameter logic [4:0] ACC_ADDR  = 5'd0,
  parameter int         MUL_ITERS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_opcode,
  input  logic [4:0] in_dest,
  input  logic [7:0] in_imm,
  input  logic [7:0] in_reg_val,
  input  logic [7:0] in_acc_val,
  input  logic       in_reg_write,
  input  logic       in_mem_write,
  output logic       stall,
  output logic [7:0] out_result,
  output logic [4:0] out_dest,
  output logic       out_reg_write,
  output logic       out_mem_write,
  output logic       out_zero,
  output logic       out_carry
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ST  = 3'd7;

  localparam int                CNT_W     = $clog2(MUL_ITERS + 1);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic             fwd;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [8:0]       sum;
  logic [8:0]       diff;
  logic [7:0]       alu_result;
  logic             alu_carry;
  logic             flags_upd;
  logic             busy_stall;
  logic             mul_start;

  logic [15:0]      mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      prod;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       cap_dest;
  logic             cap_reg_write;
  logic             cap_mem_write;

  // Forward the previous accumulator result that ID could not yet see.
  assign fwd  = out_reg_write && (out_dest == ACC_ADDR);
  assign op_a = fwd ? out_result : in_acc_val;
  assign op_b = in_reg_val;

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    flags_upd  = 1'b1;
    case (in_opcode)
      OP_NOP: flags_upd = 1'b0;
      OP_LDI: alu_result = in_imm;
      OP_ADD: begin
        alu_result = sum[7:0];
        alu_carry  = sum[8];
      end
      OP_SUB: begin
        alu_result = diff[7:0];
        alu_carry  = diff[8];
      end
      OP_AND: alu_result = op_a & op_b;
      OP_OR:  alu_result = op_a | op_b;
      OP_ST: begin
        alu_result = op_a;
        flags_upd  = 1'b0;
      end
      default: flags_upd = 1'b0;
    endcase
  end

  assign mul_start = (state == S_IDLE) && (in_opcode == OP_MUL);

  always_comb begin
    state_next = state;
    busy_stall = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_opcode == OP_MUL) begin
          busy_stall = 1'b1;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        busy_stall = 1'b1;
        if (cnt == LAST_ITER) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Stall must be low while reset is held, even if a MUL sits at the input.
  assign stall = busy_stall & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Multiplier datapath: operands and destination are captured once so the
  // upstream values are irrelevant for the rest of the operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a         <= 16'h0000;
      mul_b         <= 8'h00;
      prod          <= 16'h0000;
      cnt           <= '0;
      cap_dest      <= 5'd0;
      cap_reg_write <= 1'b0;
      cap_mem_write <= 1'b0;
    end else if (mul_start) begin
      mul_a         <= {8'h00, op_a};
      mul_b         <= op_b;
      prod          <= 16'h0000;
      cnt           <= '0;
      cap_dest      <= in_dest;
      cap_reg_write <= in_reg_write;
      cap_mem_write <= in_mem_write;
    end else if (state == S_BUSY) begin
      if (mul_b[0]) prod <= prod + mul_a;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_result    <= 8'h00;
      out_dest      <= 5'd0;
      out_reg_write <= 1'b0;
      out_mem_write <= 1'b0;
      out_zero      <= 1'b0;
      out_carry     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_opcode == OP_MUL) begin
            out_reg_write <= 1'b0;
            out_mem_write <= 1'b0;
          end else begin
            out_result    <= alu_result;
            out_dest      <= in_dest;
            out_reg_write <= in_reg_write;
            out_mem_write <= in_mem_write;
            if (flags_upd) begin
              out_zero  <= (alu_result == 8'h00);
              out_carry <= alu_carry;
            end
          end
        end
        S_DONE: begin
          out_result    <= prod[7:0];
          out_dest      <= cap_dest;
          out_reg_write <= cap_reg_write;
          out_mem_write <= cap_mem_write;
          out_zero      <= (prod[7:0] == 8'h00);
          out_carry     <= (prod[15:8] != 8'h00);
        end
        default: begin
          out_reg_write <= 1'b0;
          out_mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table for single-cycle ops plus multi-cycle MUL and reset sequences.
`default_nettype none

module tb_ex_stage;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_opcode;
  logic [4:0] in_dest;
  logic [7:0] in_imm;
  logic [7:0] in_reg_val;
  logic [7:0] in_acc_val;
  logic       in_reg_write;
  logic       in_mem_write;
  logic       stall;
  logic [7:0] out_result;
  logic [4:0] out_dest;
  logic       out_reg_write;
  logic       out_mem_write;
  logic       out_zero;
  logic       out_carry;

  int total = 0;
  int bad   = 0;

  ex_stage dut (
    .clk          (clk),
    .rst          (rst_n),
    .in_opcode    (in_opcode),
    .in_dest      (in_dest),
    .in_imm       (in_imm),
    .in_reg_val   (in_reg_val),
    .in_acc_val   (in_acc_val),
    .in_reg_write (in_reg_write),
    .in_mem_write (in_mem_write),
    .stall        (stall),
    .out_result   (out_result),
    .out_dest     (out_dest),
    .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write),
    .out_zero     (out_zero),
    .out_carry    (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [4:0] dest;
    logic [7:0] imm;
    logic [7:0] rv;
    logic [7:0] acc;
    logic       rw;
    logic       mw;
    logic [7:0] e_res;
    logic [4:0] e_dest;
    logic       e_rw;
    logic       e_mw;
    logic       e_z;
    logic       e_c;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] dest, input logic [7:0] imm,
                       input logic [7:0] rv, input logic [7:0] acc, input logic rw, input logic mw);
    in_opcode = op; in_dest = dest; in_imm = imm; in_reg_val = rv;
    in_acc_val = acc; in_reg_write = rw; in_mem_write = mw;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] res, input logic [4:0] dest,
                            input logic rw, input logic mw, input logic z, input logic c);
    check({tag, "_result"}, 16'(out_result), 16'(res));
    check({tag, "_dest"},   16'(out_dest),   16'(dest));
    check({tag, "_rw"},     16'(out_reg_write), 16'(rw));
    check({tag, "_mw"},     16'(out_mem_write), 16'(mw));
    check({tag, "_zero"},   16'(out_zero),  16'(z));
    check({tag, "_carry"},  16'(out_carry), 16'(c));
  endtask

  task automatic run_mul(input logic [7:0] acc, input logic [7:0] rv, input logic [4:0] dest,
                         input logic [7:0] hold_res, input logic [4:0] hold_dest,
                         input logic [7:0] e_res, input logic e_z, input logic e_c,
                         input bit toggle);
    drive(3'd6, dest, 8'h00, rv, acc, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      #1 check("mul_stall_hi", 16'(stall), 16'd1);
      @(posedge clk); #1;
      check("mul_bubble_rw", 16'(out_reg_write), 16'd0);
      check("mul_bubble_mw", 16'(out_mem_write), 16'd0);
      check("mul_hold_res", 16'(out_result), 16'(hold_res));
      check("mul_hold_dest", 16'(out_dest), 16'(hold_dest));
      if (toggle) begin
        in_reg_val = 8'($urandom);
        in_acc_val = 8'($urandom);
      end
    end
    #1 check("mul_done_stall_lo", 16'(stall), 16'd0);
    @(posedge clk); #1;
    check_outs("mul", e_res, dest, 1'b1, 1'b0, e_z, e_c);
  endtask

  initial begin
    // op dest imm rv acc rw mw | res dest rw mw z c
    vecs[0]  = '{3'd1, 5'd0,  8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 5'd3,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 5'd4,  8'h00, 8'h20, 8'hF0, 1'b1, 1'b0, 8'h10, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'd3, 5'd4,  8'h00, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 5'd4,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'd3, 5'd4,  8'h00, 8'h04, 8'h03, 1'b1, 1'b0, 8'hFF, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'd7, 5'd18, 8'h00, 8'h00, 8'h33, 1'b0, 1'b1, 8'h33, 5'd18, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{3'd1, 5'd0,  8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 8'h07, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 5'd4,  8'h00, 8'h03, 8'h00, 1'b1, 1'b0, 8'h0A, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd1, 5'd5,  8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 8'h07, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 5'd4,  8'h00, 8'h03, 8'h00, 1'b1, 1'b0, 8'h03, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd4, 5'd4,  8'h00, 8'h0F, 8'h3C, 1'b1, 1'b0, 8'h0C, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd5, 5'd4,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 5'd4,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'd0, 5'd1,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 5'd1,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'd1, 5'd0,  8'h44, 8'h00, 8'h00, 1'b0, 1'b0, 8'h44, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'd2, 5'd4,  8'h00, 8'h01, 8'h01, 1'b1, 1'b0, 8'h02, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'd1, 5'd0,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{3'd2, 5'd4,  8'h00, 8'h01, 8'h10, 1'b1, 1'b0, 8'h00, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held across random inputs, including MUL opcodes.
    rst_n = 1'b0;
    drive(3'd6, 5'd0, 8'hAA, 8'h55, 8'h11, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(3'($urandom), 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
      #1;
      check("rst_stall", 16'(stall), 16'd0);
      check_outs("rst", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(vecs[0].op, vecs[0].dest, vecs[0].imm, vecs[0].rv, vecs[0].acc, vecs[0].rw, vecs[0].mw);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].dest, vecs[i].imm, vecs[i].rv, vecs[i].acc, vecs[i].rw, vecs[i].mw);
      #1 check($sformatf("v%0d_stall", i), 16'(stall), 16'd0);
      @(posedge clk); #1;
      check_outs($sformatf("v%0d", i), vecs[i].e_res, vecs[i].e_dest, vecs[i].e_rw,
                 vecs[i].e_mw, vecs[i].e_z, vecs[i].e_c);
    end

    // 0x0C*0x0B = 0x84 with operands toggled during BUSY.
    run_mul(8'h0C, 8'h0B, 5'd7, 8'h00, 5'd4, 8'h84, 1'b0, 1'b0, 1'b1);
    // 0x20*0x10 = 0x0200, then a back-to-back MUL forwarding acc=0x00.
    run_mul(8'h20, 8'h10, 5'd0, 8'h84, 5'd7, 8'h00, 1'b1, 1'b1, 1'b0);
    run_mul(8'h55, 8'h09, 5'd2, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a multiply.
    drive(3'd2, 5'd31, 8'h00, 8'h20, 8'hF0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_outs("pre_mul", 8'h10, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(3'd6, 5'd9, 8'h00, 8'h0B, 8'h0C, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("mid_busy_stall", 16'(stall), 16'd1);
    check("mid_busy_hold", 16'(out_result), 16'h10);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 16'(stall), 16'd0);
    check_outs("midrst", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("midrst_stall2", 16'(stall), 16'd0);
    drive(3'd7, 5'd18, 8'h00, 8'h00, 8'h33, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    #1 check("post_rst_stall", 16'(stall), 16'd0);
    @(posedge clk); #1;
    check_outs("post_rst_st", 8'h33, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(3'd0, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("post_rst_nop_stall", 16'(stall), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
